// File: rtl/tdc_capture_ctrl.sv
// Capture sequencer for the carry-chain TDC: synchronizes the measured signal, keeps a
// tap-sample history and emits one coarse/fine timestamp per armed edge. Option: TDC_AUTO_REARM_EN.
module tdc_capture_ctrl #(
   parameter int TAPS       = 10,
   parameter int COARSE_W   = 16,
   parameter int HIST_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                arm,
   input  logic                sig_in,
   input  logic [TAPS-1:0]     tap_in,
   output logic                ts_valid,
   input  logic                ts_ready,
   output logic [COARSE_W-1:0] ts_coarse,
   output logic [3:0]          ts_fine,
   output logic                ts_bubble,
   output logic                busy,
   output logic                overrun
);

   localparam int KW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_REPORT} state_t;

`ifdef TDC_AUTO_REARM_EN
   localparam state_t AFTER_XFER = S_ARMED;
`else
   localparam state_t AFTER_XFER = S_IDLE;
`endif

   state_t                state_q, state_d;
   logic                  ovr_q, ovr_d;
   logic [COARSE_W-1:0]   cnt_q;
   logic [COARSE_W-1:0]   cntd_q;
   logic                  sq1_q, sq2_q, sq3_q;
   logic [TAPS-1:0]       t1_q;
   logic [TAPS-1:0]       hist_q [HIST_DEPTH];
   logic [TAPS-1:0]       snap_q [HIST_DEPTH];
   logic [COARSE_W-1:0]   coarse_q;
   logic [3:0]            fine_q;
   logic                  bubble_q;
   logic                  edge_w;
   logic [KW-1:0]         sel_k;
   logic [TAPS-1:0]       sel_entry;

   function automatic logic [3:0] popcount(input logic [TAPS-1:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < TAPS; i++) begin
         c = c + {3'b000, v[i]};
      end
      return c;
   endfunction

   // A clean thermometer has no set tap above a clear one.
   function automatic logic has_bubble(input logic [TAPS-1:0] v);
      logic b;
      b = 1'b0;
      for (int i = 1; i < TAPS; i++) begin
         if (v[i] && !v[i-1]) b = 1'b1;
      end
      return b;
   endfunction

   assign edge_w = sq2_q & ~sq3_q;

   // Oldest non-empty history entry marks where the edge first entered the delay line.
   always_comb begin
      sel_k     = '0;
      sel_entry = snap_q[0];
      for (int j = 0; j < HIST_DEPTH; j++) begin
         if (snap_q[j] != '0) begin
            sel_k     = KW'(j);
            sel_entry = snap_q[j];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ovr_d   = ovr_q;
      case (state_q)
         S_IDLE:    if (arm) state_d = S_ARMED;
         S_ARMED:   if (edge_w) state_d = S_CAPTURE;
         S_CAPTURE: begin
            state_d = S_REPORT;
            if (edge_w) ovr_d = 1'b1;
         end
         S_REPORT:  begin
            if (edge_w) ovr_d = 1'b1;
            if (ts_ready) state_d = AFTER_XFER;
         end
         default:   state_d = S_IDLE;
      endcase
      if (arm) ovr_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         ovr_q    <= 1'b0;
         cnt_q    <= '0;
         cntd_q   <= '0;
         sq1_q    <= 1'b0;
         sq2_q    <= 1'b0;
         sq3_q    <= 1'b0;
         t1_q     <= '0;
         coarse_q <= '0;
         fine_q   <= '0;
         bubble_q <= 1'b0;
         for (int j = 0; j < HIST_DEPTH; j++) begin
            hist_q[j] <= '0;
            snap_q[j] <= '0;
         end
      end else begin
         state_q <= state_d;
         ovr_q   <= ovr_d;
         cnt_q   <= cnt_q + COARSE_W'(1);
         sq1_q   <= sig_in;
         sq2_q   <= sq1_q;
         sq3_q   <= sq2_q;
         t1_q    <= tap_in;
         hist_q[0] <= t1_q;
         for (int j = 1; j < HIST_DEPTH; j++) begin
            hist_q[j] <= hist_q[j-1];
         end
         if (state_q == S_ARMED && edge_w) begin
            cntd_q <= cnt_q;
            for (int j = 0; j < HIST_DEPTH; j++) begin
               snap_q[j] <= hist_q[j];
            end
         end
         if (state_q == S_CAPTURE) begin
            coarse_q <= cntd_q - COARSE_W'(sel_k);
            fine_q   <= popcount(sel_entry);
            bubble_q <= has_bubble(sel_entry);
         end
      end
   end

   assign ts_valid  = (state_q == S_REPORT);
   assign busy      = (state_q != S_IDLE);
   assign overrun   = ovr_q;
   assign ts_coarse = coarse_q;
   assign ts_fine   = fine_q;
   assign ts_bubble = bubble_q;

endmodule
